maj_vote_filter: RTL and testbench
==================================

MAJ_VOTE_FILTER -- requirements
Module: maj_vote_filter

Interface
REQ-001 Parameter N, 3, channel count; SHALL be odd and >= 3.
REQ-002 Parameter W, 8, data bits per channel; SHALL be >= 1.
REQ-003 Parameter HOLD, 4, consecutive identical valid majority samples required before the output updates; SHALL be >= 1.
REQ-004 Parameter FAULT_LIM, 3, consecutive disagreeing valid samples before a channel is flagged faulty; SHALL be >= 1.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  the current data sample is evaluated.
REQ-008 data  in  N*W  channel i occupies bits [i*W +: W].
REQ-009 fault_clr  in  1  single-cycle pulse that clears all fault flags and counters.
REQ-010 vote_out  out  W  registered, filtered majority value.
REQ-011 vote_upd  out  1  one-cycle pulse when vote_out is loaded.
REQ-012 disagree  out  1  registered; some channel differed from the majority on the previous valid sample.
REQ-013 fault  out  N  sticky per-channel fault flags.

Function
REQ-014 maj SHALL be the bitwise majority of the channels: bit b is 1 iff more than N/2 channels have bit b = 1 (combinational).
REQ-015 When in_valid = 0, all state and outputs SHALL hold, except vote_upd and disagree, which SHALL be 0.
REQ-016 FSM states SHALL be EMPTY (no sample since reset), SETTLING (candidate not committed), and LOCKED (vote_out = cand and cnt = HOLD).
REQ-017 On a valid sample: cnt_next = min(cnt+1, HOLD) if state != EMPTY and maj = cand, otherwise 1; cand_next = maj.
REQ-018 Commit SHALL occur on a valid sample when cnt_next = HOLD and (state != LOCKED or maj != vote_out).
REQ-019 On commit, vote_out <= maj and vote_upd = 1 in the next cycle; state <= LOCKED.
REQ-020 A valid sample that does not commit SHALL move state to SETTLING if maj != vote_out or state = EMPTY; a LOCKED sample with maj = vote_out SHALL stay LOCKED.
REQ-021 Latency: vote_out changes in the cycle after the HOLD-th consecutive identical valid sample; with HOLD = 1, the cycle after each changing sample. Cycles with in_valid = 0 SHALL NOT break the run.
REQ-022 Per channel i, on a valid sample: if data_i != maj, then dcnt[i] = min(dcnt[i]+1, FAULT_LIM); otherwise dcnt[i] = 0.
REQ-023 fault[i] SHALL be set when dcnt[i] reaches FAULT_LIM, and SHALL stay set until fault_clr.
REQ-024 fault_clr SHALL zero fault and dcnt. A valid sample in the same cycle SHALL be evaluated with dcnt treated as 0; a resulting set wins.
REQ-025 disagree SHALL be 1 for one cycle after a valid sample on which any data_i != maj.

Reset
REQ-026 While resetn = 0, the block SHALL asynchronously force: vote_out = 0, vote_upd = 0, disagree = 0, fault = 0, cand = 0, cnt = 0, dcnt = 0, state = EMPTY.
REQ-027 Reset mid-SETTLING or mid-LOCKED SHALL discard all progress; after deassertion, HOLD fresh valid samples are required before a commit.

Structure
REQ-028 The state encodings (EMPTY/SETTLING/LOCKED) and the parameter legality checks SHALL live in the shared package maj_vote_pkg.
REQ-029 The bitwise N-input majority SHALL be the combinational sub-module maj_bits (parameters N, W), instantiated once.
REQ-030 Target size: 120-400 lines of RTL.

Verification (N=3, W=8, HOLD=4, FAULT_LIM=3)
REQ-031 Reset, then 4 valid samples with all channels at 0xA5 -> vote_out = 0xA5 and vote_upd pulse the cycle after the 4th; after only 3 samples -> vote_out = 0x00 and no pulse.
REQ-032 Channels 0x0F/0x33/0x55 held for 4 valid samples -> vote_out = 0x17; disagree = 1 each sample; all three fault bits set after the 3rd sample.
REQ-033 Channels 0xA5/0xA5/0x5A for 3 samples -> fault = 3'b100; it stays set on later agreement; fault_clr -> 3'b000. fault_clr together with a disagreeing sample at FAULT_LIM=1 -> flag set.
REQ-034 LOCKED at 0xA5, one valid 0x3C sample, then 0xA5 x4 with in_valid gaps between -> vote_out stays 0xA5 and no vote_upd pulse.
REQ-035 resetn asserted after 2 of 4 samples -> all outputs 0 and state EMPTY; 4 further samples are needed to commit.

Source files
------------

// File: rtl/maj_vote_pkg.sv
// Shared definitions for the majority-vote filter: FSM encodings and
// the elaboration-time parameter legality check.
package maj_vote_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,   // no sample seen since reset
      ST_SETTLING = 2'd1,   // candidate still building its run
      ST_LOCKED   = 2'd2    // vote_out equals the committed candidate
   } state_e;

   // N odd and >= 3, W >= 1, HOLD >= 1, FAULT_LIM >= 1.
   function automatic bit params_ok(input int n, input int w,
                                    input int hold, input int flim);
      return (n >= 3) && (n % 2 == 1) && (w >= 1) && (hold >= 1) && (flim >= 1);
   endfunction

endpackage

// File: rtl/maj_vote_filter_if.sv
// Sample/result bundle between the producer of redundant channel data
// and the majority-vote filter.
interface maj_vote_filter_if #(
   parameter int N = 3,
   parameter int W = 8
) ();
   logic               in_valid;
   logic [N*W-1:0]     data;
   logic               fault_clr;
   logic [W-1:0]       vote_out;
   logic               vote_upd;
   logic               disagree;
   logic [N-1:0]       fault;

   modport master (
      output in_valid, data, fault_clr,
      input  vote_out, vote_upd, disagree, fault
   );

   modport slave (
      input  in_valid, data, fault_clr,
      output vote_out, vote_upd, disagree, fault
   );
endinterface

// File: rtl/maj_bits.sv
// Combinational bitwise majority across N channels of W bits each.
module maj_bits #(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic [N*W-1:0] data_i,
   output logic [W-1:0]   maj_o
);
   int ones;

   // Per bit position: count ones across channels, majority if > N/2.
   always_comb begin
      maj_o = '0;
      ones  = 0;
      for (int b = 0; b < W; b++) begin
         ones = 0;
         for (int i = 0; i < N; i++) begin
            ones = ones + int'(data_i[i*W + b]);
         end
         maj_o[b] = (ones > N / 2);
      end
   end
endmodule

// File: rtl/maj_vote_filter.sv
// Majority-vote filter: votes N redundant channels bitwise, commits the
// vote only after HOLD consecutive identical valid majorities, and
// flags channels that disagree with the majority FAULT_LIM times in a row.
module maj_vote_filter
   import maj_vote_pkg::*;
#(
   parameter int N         = 3,
   parameter int W         = 8,
   parameter int HOLD      = 4,
   parameter int FAULT_LIM = 3
) (
   input  logic                 clk,
   input  logic                 resetn,
   maj_vote_filter_if.slave     bus
);
   localparam int CW = $clog2(HOLD + 1);
   localparam int FW = $clog2(FAULT_LIM + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
   localparam logic [CW-1:0] CONE_C = CW'(1);
   localparam logic [FW-1:0] LIM_C  = FW'(FAULT_LIM);
   localparam logic [FW-1:0] FONE_C = FW'(1);

   if (!params_ok(N, W, HOLD, FAULT_LIM)) begin : g_bad_params
      $error("maj_vote_filter: illegal parameter set");
   end

   state_e                 state_q, state_d;
   logic [W-1:0]           cand_q, cand_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_nx;
   logic [W-1:0]           vote_q, vote_d;
   logic                   upd_q, upd_d;
   logic                   dis_q, dis_d;
   logic [N-1:0]           fault_q, fault_d;
   logic [N-1:0][FW-1:0]   dcnt_q, dcnt_d;
   logic [N-1:0]           mism;
   logic [W-1:0]           maj;
   logic                   run, commit;

   maj_bits #(.N(N), .W(W)) u_maj (
      .data_i (bus.data),
      .maj_o  (maj)
   );

   // Per-channel disagreement counters and sticky fault flags; a clear
   // pulse zeroes the history first so a same-cycle sample starts from 0.
   always_comb begin
      mism    = '0;
      dcnt_d  = dcnt_q;
      fault_d = fault_q;
      for (int i = 0; i < N; i++) begin
         logic [FW-1:0] base;
         mism[i]    = (bus.data[i*W +: W] != maj);
         base       = bus.fault_clr ? '0 : dcnt_q[i];
         dcnt_d[i]  = base;
         fault_d[i] = bus.fault_clr ? 1'b0 : fault_q[i];
         if (bus.in_valid) begin
            if (mism[i])
               dcnt_d[i] = (base == LIM_C) ? LIM_C : base + FONE_C;
            else
               dcnt_d[i] = '0;
            if (dcnt_d[i] == LIM_C)
               fault_d[i] = 1'b1;
         end
      end
   end

   // Vote FSM: track the run length of the current candidate and commit
   // it once the run reaches HOLD and would actually change the output.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      vote_d  = vote_q;
      upd_d   = 1'b0;
      dis_d   = 1'b0;
      run     = (state_q != ST_EMPTY) && (maj == cand_q);
      cnt_nx  = !run ? CONE_C : ((cnt_q == HOLD_C) ? HOLD_C : cnt_q + CONE_C);
      commit  = (cnt_nx == HOLD_C) && ((state_q != ST_LOCKED) || (maj != vote_q));
      if (bus.in_valid) begin
         cand_d = maj;
         cnt_d  = cnt_nx;
         dis_d  = |mism;
         if (commit) begin
            vote_d  = maj;
            upd_d   = 1'b1;
            state_d = ST_LOCKED;
         end else if ((state_q == ST_EMPTY) || (maj != vote_q)) begin
            state_d = ST_SETTLING;
         end else begin
            // Majority is back on the held value: nothing to reload, so a
            // transient glitch never produces a redundant update pulse.
            state_d = ST_LOCKED;
         end
      end
   end

   // State register; reset discards all progress.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_EMPTY;
         cand_q  <= '0;
         cnt_q   <= '0;
         vote_q  <= '0;
         upd_q   <= 1'b0;
         dis_q   <= 1'b0;
         fault_q <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         vote_q  <= vote_d;
         upd_q   <= upd_d;
         dis_q   <= dis_d;
         fault_q <= fault_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign bus.vote_out = vote_q;
   assign bus.vote_upd = upd_q;
   assign bus.disagree = dis_q;
   assign bus.fault    = fault_q;
endmodule

// File: tb/tb_maj_vote_filter.sv
// Directed bench for maj_vote_filter: a vector table for the main flow
// plus hand sequences for glitch rejection, mid-run reset and fault_clr
// collisions on a FAULT_LIM=1 instance.
module tb_maj_vote_filter;
   import maj_vote_pkg::*;

   localparam logic [23:0] AAA = 24'hA5A5A5;
   localparam logic [23:0] MIX = 24'h55330F;
   localparam logic [23:0] ODD = 24'h5AA5A5;

   typedef struct {
      logic        v;
      logic [23:0] d;
      logic        clr;
      logic [7:0]  e_vote;
      logic        e_upd;
      logic        e_dis;
      logic [2:0]  e_fault;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;

   maj_vote_filter_if #(.N(3), .W(8)) bus ();
   maj_vote_filter_if #(.N(3), .W(8)) bus1 ();

   maj_vote_filter #(.N(3), .W(8), .HOLD(4), .FAULT_LIM(3)) u_dut (
      .clk(clk), .resetn(resetn), .bus(bus));
   maj_vote_filter #(.N(3), .W(8), .HOLD(4), .FAULT_LIM(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [23:0] d, input logic c);
      @(negedge clk);
      bus.in_valid  = v;
      bus.data      = d;
      bus.fault_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic v, input logic [23:0] d, input logic c);
      @(negedge clk);
      bus1.in_valid  = v;
      bus1.data      = d;
      bus1.fault_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] v, input logic u,
                          input logic ds, input logic [2:0] f);
      chk({tag, ".vote"},  32'(bus.vote_out), 32'(v));
      chk({tag, ".upd"},   32'(bus.vote_upd), 32'(u));
      chk({tag, ".dis"},   32'(bus.disagree), 32'(ds));
      chk({tag, ".fault"}, 32'(bus.fault),    32'(f));
   endtask

   function automatic vec_t mk(input logic v, input logic [23:0] d, input logic c,
                               input logic [7:0] ev, input logic eu, input logic ed,
                               input logic [2:0] ef);
      vec_t r;
      r.v = v; r.d = d; r.clr = c;
      r.e_vote = ev; r.e_upd = eu; r.e_dis = ed; r.e_fault = ef;
      return r;
   endfunction

   vec_t tbl[24];

   initial begin
      // {valid, data, clr} -> {vote, upd, disagree, fault} after the edge
      tbl[0]  = mk(1, AAA, 0, 8'h00, 0, 0, 3'b000);
      tbl[1]  = mk(1, AAA, 0, 8'h00, 0, 0, 3'b000);
      tbl[2]  = mk(1, AAA, 0, 8'h00, 0, 0, 3'b000);
      tbl[3]  = mk(1, AAA, 0, 8'hA5, 1, 0, 3'b000);
      tbl[4]  = mk(0, MIX, 0, 8'hA5, 0, 0, 3'b000);
      tbl[5]  = mk(1, AAA, 0, 8'hA5, 0, 0, 3'b000);
      tbl[6]  = mk(1, MIX, 0, 8'hA5, 0, 1, 3'b000);
      tbl[7]  = mk(1, MIX, 0, 8'hA5, 0, 1, 3'b000);
      tbl[8]  = mk(0, MIX, 0, 8'hA5, 0, 0, 3'b000);
      tbl[9]  = mk(1, MIX, 0, 8'hA5, 0, 1, 3'b111);
      tbl[10] = mk(1, MIX, 0, 8'h17, 1, 1, 3'b111);
      tbl[11] = mk(0, AAA, 1, 8'h17, 0, 0, 3'b000);
      tbl[12] = mk(1, ODD, 0, 8'h17, 0, 1, 3'b000);
      tbl[13] = mk(1, ODD, 0, 8'h17, 0, 1, 3'b000);
      tbl[14] = mk(1, ODD, 0, 8'h17, 0, 1, 3'b100);
      tbl[15] = mk(1, AAA, 0, 8'hA5, 1, 0, 3'b100);
      tbl[16] = mk(1, AAA, 0, 8'hA5, 0, 0, 3'b100);
      tbl[17] = mk(0, AAA, 1, 8'hA5, 0, 0, 3'b000);
      tbl[18] = mk(1, ODD, 0, 8'hA5, 0, 1, 3'b000);
      tbl[19] = mk(1, ODD, 0, 8'hA5, 0, 1, 3'b000);
      tbl[20] = mk(1, ODD, 1, 8'hA5, 0, 1, 3'b000);
      tbl[21] = mk(1, ODD, 0, 8'hA5, 0, 1, 3'b000);
      tbl[22] = mk(1, ODD, 0, 8'hA5, 0, 1, 3'b100);
      tbl[23] = mk(0, AAA, 1, 8'hA5, 0, 0, 3'b000);

      bus.in_valid = 0;  bus.data = '0;  bus.fault_clr = 0;
      bus1.in_valid = 0; bus1.data = '0; bus1.fault_clr = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 8'h00, 0, 0, 3'b000);
      chk("reset.state", 32'(u_dut.state_q), 32'(ST_EMPTY));
      @(negedge clk);
      resetn = 1'b1;

      // Main flow from the table
      for (int i = 0; i < 24; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].clr);
         chk_all($sformatf("row%0d", i), tbl[i].e_vote, tbl[i].e_upd,
                 tbl[i].e_dis, tbl[i].e_fault);
      end

      // One-sample glitch while locked, then the held value with gaps
      step(1, 24'h3C3C3C, 0);
      chk("glitch.vote", 32'(bus.vote_out), 32'h0A5);
      chk("glitch.upd",  32'(bus.vote_upd), 32'h0);
      for (int k = 0; k < 4; k++) begin
         step(0, AAA, 0);
         chk($sformatf("gap%0d.vote", k), 32'(bus.vote_out), 32'h0A5);
         chk($sformatf("gap%0d.upd", k),  32'(bus.vote_upd), 32'h0);
         step(1, AAA, 0);
         chk($sformatf("back%0d.vote", k), 32'(bus.vote_out), 32'h0A5);
         chk($sformatf("back%0d.upd", k),  32'(bus.vote_upd), 32'h0);
      end
      chk("glitch.state", 32'(u_dut.state_q), 32'(ST_LOCKED));

      // Build up fault and a partial run, then reset mid-settling
      repeat (3) step(1, ODD, 0);
      chk("pre.fault", 32'(bus.fault), 32'h4);
      step(1, 24'h666667, 0);
      step(1, 24'h666667, 0);
      chk_all("pre_rst", 8'hA5, 0, 1, 3'b100);
      #2;
      resetn = 1'b0;
      #1;
      chk_all("async_rst", 8'h00, 0, 0, 3'b000);
      chk("async_rst.state", 32'(u_dut.state_q), 32'(ST_EMPTY));
      bus.in_valid = 0;
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1, 24'h666666, 0);
         chk($sformatf("fresh%0d.vote", k), 32'(bus.vote_out), 32'h0);
         chk($sformatf("fresh%0d.upd", k),  32'(bus.vote_upd), 32'h0);
      end
      step(1, 24'h666666, 0);
      chk("fresh3.vote", 32'(bus.vote_out), 32'h066);
      chk("fresh3.upd",  32'(bus.vote_upd), 32'h1);
      step(0, 24'h666666, 0);
      chk("fresh4.upd",  32'(bus.vote_upd), 32'h0);

      // FAULT_LIM=1 instance: clear pulse against a same-cycle sample
      step1(1, ODD, 0);
      chk("lim1.set", 32'(bus1.fault), 32'h4);
      step1(1, AAA, 1);
      chk("lim1.clr", 32'(bus1.fault), 32'h0);
      step1(1, ODD, 1);
      chk("lim1.clr_and_set", 32'(bus1.fault), 32'h4);
      chk("lim1.dis", 32'(bus1.disagree), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
